// File: rtl/ifu_if.sv
// ifu_if: controller/memory-facing signal bundle of the instruction fetch unit
interface ifu_if;
  logic        pcwr;
  logic        irwr;
  logic [1:0]  npc_sel;
  logic        br_take;
  logic [31:0] jr_target;
  logic [31:0] im_dout;
  logic [14:0] im_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic        fault;
  logic [31:0] bad_pc;
  logic [31:0] icount;
  modport master (
    output pcwr, irwr, npc_sel, br_take, jr_target, im_dout,
    input  im_addr, pc, pc_plus4, ir, fault, bad_pc, icount
  );
  modport slave (
    input  pcwr, irwr, npc_sel, br_take, jr_target, im_dout,
    output im_addr, pc, pc_plus4, ir, fault, bad_pc, icount
  );
endinterface

// File: rtl/ifu.sv
// ifu: PC/IR owner with next-PC select, range/alignment check and sticky fetch fault
module ifu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_BYTES = 8192
) (
  input logic   clk,
  input logic   rst,
  ifu_if.slave  bus
);
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_BYTES) - 32'd4;
  logic [31:0] r_pc, r_ir, r_bad_pc, r_icount;
  logic        r_fault;
  logic [31:0] w_pc4, w_br, w_jmp, w_npc;
  logic        w_legal;
  assign w_pc4 = r_pc + 32'd4;
  // branch offset is relative to the already-advanced pc
  assign w_br  = r_pc + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_jmp = {r_pc[31:28], r_ir[25:0], 2'b00};
  always_comb
    w_npc = bus.npc_sel == 2'b00 ? w_pc4 :
            bus.npc_sel == 2'b01 ? (bus.br_take ? w_br : r_pc) :
            bus.npc_sel == 2'b10 ? w_jmp : bus.jr_target;
  assign w_legal = w_npc[1:0] == 2'b00 && w_npc >= IM_BASE && w_npc <= IM_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc     <= PC_RESET;
      r_ir     <= '0;
      r_fault  <= 1'b0;
      r_bad_pc <= '0;
      r_icount <= '0;
    end else if (!r_fault) begin
      if (bus.pcwr) begin
        if (w_legal) r_pc <= w_npc;
        else begin
          r_fault  <= 1'b1;
          r_bad_pc <= w_npc;
        end
      end
      if (bus.irwr) begin
        r_ir     <= bus.im_dout;
        r_icount <= r_icount + 32'd1;
      end
    end
  assign bus.im_addr  = r_pc[14:0];
  assign bus.pc       = r_pc;
  assign bus.pc_plus4 = w_pc4;
  assign bus.ir       = r_ir;
  assign bus.fault    = r_fault;
  assign bus.bad_pc   = r_bad_pc;
  assign bus.icount   = r_icount;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed vector table plus hand sequences for fault, reset and async reset
module tb_ifu;
  logic clk = 1'b0;
  logic rst;
  ifu_if bus ();
  ifu dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [31:0] mem [0:2047];
  logic [14:0] w_off;
  assign w_off = bus.im_addr - 15'h3000;
  assign bus.im_dout = mem[w_off[12:2]];
  typedef struct {
    logic        pcwr;
    logic        irwr;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] jr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fault;
    logic [31:0] bad;
    logic [31:0] cnt;
  } vec_t;
  vec_t tv[$];
  int n_chk = 0;
  int n_err = 0;
  localparam logic [31:0] A = 32'h0800_0C05;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;
  localparam logic [31:0] W = 32'h1000_FFFC;
  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] E = 32'h0E0E_0E0E;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk_state(input string nm, input logic [31:0] pc, input logic [31:0] ir,
                           input logic fault, input logic [31:0] bad, input logic [31:0] cnt);
    chk({nm, " pc"}, bus.pc, pc);
    chk({nm, " im_addr"}, {17'd0, bus.im_addr}, {17'd0, pc[14:0]});
    chk({nm, " pc_plus4"}, bus.pc_plus4, pc + 32'd4);
    chk({nm, " ir"}, bus.ir, ir);
    chk({nm, " fault"}, {31'd0, bus.fault}, {31'd0, fault});
    chk({nm, " bad_pc"}, bus.bad_pc, bad);
    chk({nm, " icount"}, bus.icount, cnt);
  endtask
  task automatic drive(input logic pw, input logic iw, input logic [1:0] sel,
                       input logic br, input logic [31:0] jr);
    bus.pcwr = pw;
    bus.irwr = iw;
    bus.npc_sel = sel;
    bus.br_take = br;
    bus.jr_target = jr;
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[0] = A;
    mem[1] = B;
    mem[2] = C;
    mem[3] = W;
    mem[32'h40] = D;
    mem[2047] = E;
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h3000_3004 & 32'hFFFF, A, 1'b0, 32'h0, 32'd1});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h3008, B, 1'b0, 32'h0, 32'd2});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h300C, C, 1'b0, 32'h0, 32'd3});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h3010, W, 1'b0, 32'h0, 32'd4});
    tv.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,    32'h3010, W, 1'b0, 32'h0, 32'd4});
    tv.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h0,    32'h3010, W, 1'b0, 32'h0, 32'd4});
    tv.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h0,    32'h3000, W, 1'b0, 32'h0, 32'd4});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h3004, A, 1'b0, 32'h0, 32'd5});
    tv.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0,    32'h3014, A, 1'b0, 32'h0, 32'd5});
    tv.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 32'h3100, 32'h3100, A, 1'b0, 32'h0, 32'd5});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h3104, D, 1'b0, 32'h0, 32'd6});
    tv.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 32'h4FFC, 32'h4FFC, D, 1'b0, 32'h0, 32'd6});
    tv.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0,    32'h4FFC, E, 1'b0, 32'h0, 32'd7});
    tv.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0,    32'h4FFC, E, 1'b1, 32'h5000, 32'd8});
    tv.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 32'h3000, 32'h4FFC, E, 1'b1, 32'h5000, 32'd8});
    tv.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0,    32'h4FFC, E, 1'b1, 32'h5000, 32'd8});
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    #2;
    chk_state("reset", 32'h3000, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i].pcwr, tv[i].irwr, tv[i].sel, tv[i].br, tv[i].jr);
      @(posedge clk);
      @(negedge clk);
      chk_state($sformatf("v%0d", i), tv[i].pc, tv[i].ir, tv[i].fault, tv[i].bad, tv[i].cnt);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_state("rst_clears_fault", 32'h3000, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h3102);
    @(posedge clk);
    @(negedge clk);
    chk_state("misalign", 32'h3000, 32'h0, 1'b1, 32'h3102, 32'h0);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk_state("misalign_frozen", 32'h3000, 32'h0, 1'b1, 32'h3102, 32'h0);
    rst = 1'b1;
    #1;
    chk_state("misalign_rst", 32'h3000, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h2FFC);
    @(posedge clk);
    @(negedge clk);
    chk_state("below_base", 32'h3000, 32'h0, 1'b1, 32'h2FFC, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk_state("pre_async", 32'h3004, A, 1'b0, 32'h0, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 32'h3000, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_state("post_async", 32'h3000, 32'h0, 1'b0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
